// File: rtl/axi_lite_imem.sv
// axi_lite_imem: AXI4-Lite read-only instruction memory slave.
//
// It returns one 32-bit word per AR request. There is only ever one
// transaction in flight. READ_LATENCY wait cycles (0..15) sit between the
// AR handshake and the first rvalid cycle, so one AR-to-rvalid trip takes
// READ_LATENCY+1 cycles. A side load port writes program words at any time.
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid && ready are both high. Once rvalid is raised, it stays high, and
// rdata/rresp stay unchanged, until the edge where rready is also high.
// arready is low while RST is high. During the response it follows rready,
// so a new AR can be taken in the same cycle as the R handshake.
//
// Memory powers up unknown and must be filled through the load port.
//
// Ports:
//   CLK, RST              clock (rising edge), synchronous active-high reset
//   s_axi_ar*             read address channel (arprot is ignored)
//   s_axi_r*              read data channel; rresp 00 OKAY, 10 SLVERR
//   load_en/addr/data     one-word write port; byte address, low bits ignored
`timescale 1ns/1ps
module axi_lite_imem #(
    parameter int    ADDR_WIDTH   = 32,
    parameter int    DATA_WIDTH   = 32,
    parameter int    PROT_WIDTH   = 3,
    parameter int    RESP_WIDTH   = 2,
    parameter int    MEM_DEPTH    = 1024,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "imem.hex"
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [PROT_WIDTH-1:0] s_axi_arprot,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [RESP_WIDTH-1:0] s_axi_rresp,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int MW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [IDX_W-1:0]      DEPTH_IDX   = IDX_W'(MEM_DEPTH);
    localparam logic [3:0]            WAIT_INIT   = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state_q, next_state;
    logic [3:0]            count_q, next_count;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [RESP_WIDTH-1:0] rresp_q;

    logic                  ar_open;
    logic                  arready;
    logic                  ar_hs;
    logic                  capture;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [IDX_W-1:0]      cap_idx;
    logic                  cap_ok;
    logic [IDX_W-1:0]      load_idx;
    logic                  load_ok;

    // These bits carry no meaning for this slave.
    logic unused_bits;
    assign unused_bits = ^{s_axi_arprot, load_addr[1:0]};

    assign ar_hs = arready && s_axi_arvalid;

    always_comb begin
        next_state = state_q;
        next_count = count_q;
        ar_open    = 1'b0;
        capture    = 1'b0;
        cap_addr   = addr_q;
        case (state_q)
            IDLE: ar_open = 1'b1;
            WAIT: begin
                if (count_q == 4'd0) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end else begin
                    next_count = count_q - 4'd1;
                end
            end
            RESP: begin
                ar_open = s_axi_rready;
                if (s_axi_rready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        arready = ar_open && !RST;

        // An accepted AR overrides the IDLE/RESP choice above. With zero
        // latency the word is captured straight from the incoming address.
        if (arready && s_axi_arvalid) begin
            if (READ_LATENCY > 0) begin
                next_state = WAIT;
                next_count = WAIT_INIT;
            end else begin
                next_state = RESP;
                capture    = 1'b1;
                cap_addr   = s_axi_araddr;
            end
        end
    end

    // The full upper address is compared, so an address past the end
    // never wraps onto a real word.
    assign cap_idx  = cap_addr[ADDR_WIDTH-1:2];
    assign cap_ok   = (cap_addr[1:0] == 2'b00) && (cap_idx < DEPTH_IDX);
    assign load_idx = load_addr[ADDR_WIDTH-1:2];
    assign load_ok  = load_idx < DEPTH_IDX;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            addr_q  <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            state_q <= next_state;
            count_q <= next_count;
            if (ar_hs) addr_q <= s_axi_araddr;
            if (capture) begin
                rdata_q <= cap_ok ? mem[cap_idx[MW-1:0]] : '0;
                rresp_q <= cap_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // A capture and a load on the same word at the same edge return the
    // old word, because both are non-blocking updates at that edge.
    always_ff @(posedge CLK) begin
        if (load_en && load_ok) mem[load_idx[MW-1:0]] <= load_data;
    end

    localparam string unused_init_file = INIT_FILE;

    assign s_axi_arready = arready;
    assign s_axi_rvalid  = (state_q == RESP);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

endmodule
